light_pattern_player: RTL and testbench

Parametrised successor to the single-pattern light driver. It drives `NUM_LIGHTS` outputs with one of four selectable patterns (all-on, chase, blink, alternate) for a programmed duration in milliseconds, then reports completion. It sits between the show sequencer, which issues `go` and waits for `finished`, and the light output pins. All control is synchronous to `clk`; `go` is sampled as a data input, never used as a clock.

---
 rtl/light_pkg.sv | 17 +
 rtl/ms_tick_gen.sv | 32 +++
 rtl/light_pattern_player.sv | 140 ++++++++++++++
 tb/tb_light_pattern_player.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types for the light pattern player and its helpers.
package light_pkg;

  typedef enum logic [1:0] {
    ALL_ON    = 2'd0,
    CHASE     = 2'd1,
    BLINK     = 2'd2,
    ALTERNATE = 2'd3
  } light_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } player_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled clk cycles and pulses tick once
// every CLKS_PER_MS of them. clr restarts the count from zero.
module ms_tick_gen
  import light_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_MS - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/light_pattern_player.sv
// Plays one of four light patterns for a programmed number of milliseconds,
// then pulses finished. Optional abort input enabled by LIGHT_PATTERN_ABORT_EN.
module light_pattern_player
  import light_pkg::*;
#(
  parameter int NUM_LIGHTS  = 8,
  parameter int CLKS_PER_MS = 50000,
  parameter int DUR_W       = 16,
  parameter int STEP_MS     = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [1:0]            mode,
  input  logic [DUR_W-1:0]      duration_ms,
`ifdef LIGHT_PATTERN_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  finished,
  output logic [NUM_LIGHTS-1:0] lights
);

  localparam int STEP_W = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MS - 1);

  player_state_e         state_q;
  player_state_e         state_d;
  logic                  accept;
  logic                  abort_req;
  logic                  ms_tick;
  light_mode_e           mode_q;
  logic [DUR_W-1:0]      dur_q;
  logic [DUR_W-1:0]      ms_elapsed;
  logic [STEP_W-1:0]     step_cnt;
  logic [NUM_LIGHTS-1:0] pattern_q;
  logic [NUM_LIGHTS-1:0] alt_mask;
  logic [NUM_LIGHTS-1:0] init_pattern;
  logic [NUM_LIGHTS-1:0] next_pattern;

`ifdef LIGHT_PATTERN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_ms_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == RUN),
    .clr  (accept),
    .tick (ms_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A duration match and an abort in the same cycle both just select DONE,
  // so they can never produce two pulses.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if ((ms_elapsed == dur_q) || abort_req) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alt_mask = '0;
    for (int i = 0; i < NUM_LIGHTS; i += 2) begin
      alt_mask[i] = 1'b1;
    end
    case (light_mode_e'(mode))
      ALL_ON:    init_pattern = '1;
      CHASE:     init_pattern = NUM_LIGHTS'(1);
      BLINK:     init_pattern = '1;
      ALTERNATE: init_pattern = alt_mask;
      default:   init_pattern = '0;
    endcase
    case (mode_q)
      ALL_ON:    next_pattern = pattern_q;
      CHASE:     next_pattern = {pattern_q[NUM_LIGHTS-2:0], pattern_q[NUM_LIGHTS-1]};
      BLINK:     next_pattern = ~pattern_q;
      ALTERNATE: next_pattern = ~pattern_q;
      default:   next_pattern = pattern_q;
    endcase
  end

  // ms_tick only fires in RUN, so the elapsed count and step counter freeze
  // everywhere else; the duration compare always exits before a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= ALL_ON;
      dur_q      <= '0;
      ms_elapsed <= '0;
      step_cnt   <= '0;
      pattern_q  <= '0;
    end else if (accept) begin
      mode_q     <= light_mode_e'(mode);
      dur_q      <= duration_ms;
      ms_elapsed <= '0;
      step_cnt   <= '0;
      pattern_q  <= init_pattern;
    end else if (ms_tick) begin
      ms_elapsed <= ms_elapsed + 1'b1;
      if (step_cnt == STEP_LAST) begin
        step_cnt  <= '0;
        pattern_q <= next_pattern;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    finished = (state_q == DONE);
    lights   = (state_q == RUN) ? pattern_q : '0;
  end

endmodule

// File: tb/tb_light_pattern_player.sv
// Randomized self-checking bench for light_pattern_player; two instances with
// different geometry are compared against a cycle-arithmetic reference model.
module tb_light_pattern_player;

  localparam int N1 = 8;
  localparam int C1 = 4;
  localparam int S1 = 1;
  localparam int N2 = 5;
  localparam int C2 = 3;
  localparam int S2 = 3;

`ifdef LIGHT_PATTERN_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] duration_ms = 16'd0;
`ifdef LIGHT_PATTERN_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy1, fin1, busy2, fin2;
  logic [N1-1:0] lights1;
  logic [N2-1:0] lights2;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  light_pattern_player #(
    .NUM_LIGHTS(N1), .CLKS_PER_MS(C1), .DUR_W(16), .STEP_MS(S1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .duration_ms(duration_ms),
`ifdef LIGHT_PATTERN_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .finished(fin1), .lights(lights1)
  );

  light_pattern_player #(
    .NUM_LIGHTS(N2), .CLKS_PER_MS(C2), .DUR_W(16), .STEP_MS(S2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .duration_ms(duration_ms),
`ifdef LIGHT_PATTERN_ABORT_EN
    .abort(abort),
`endif
    .busy(busy2), .finished(fin2), .lights(lights2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, actual, expected);
    end
  endtask

  // Cycle (counted from the accept cycle) in which DONE is shown.
  function automatic int doneCycle(input int cpm, input int dur, input int abort_at);
    int d;
    d = dur * cpm + 2;
    if (abort_at >= 1 && abort_at <= dur * cpm + 1) d = abort_at + 1;
    return d;
  endfunction

  // Expected lights in cycle n: each ms tick lands at k*cpm and a completed
  // step is visible one cycle later, so steps done = ((n-1)/cpm)/step.
  function automatic logic [31:0] modelLights(input int n_lights, input int cpm, input int step,
                                              input int md, input int n, input int done);
    int steps;
    logic [31:0] ones, alt, r;
    if (n < 1 || n >= done) return 32'd0;
    steps = ((n - 1) / cpm) / step;
    ones = (32'd1 << n_lights) - 32'd1;
    alt = 32'd0;
    for (int i = 0; i < n_lights; i += 2) alt[i] = 1'b1;
    case (md)
      0:       r = ones;
      1:       r = 32'd1 << (steps % n_lights);
      2:       r = (steps % 2 == 1) ? 32'd0 : ones;
      default: r = (steps % 2 == 1) ? (ones ^ alt) : alt;
    endcase
    return r;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy1"}, 32'(busy1), 32'd0);
    checkOutput({tag, " finished1"}, 32'(fin1), 32'd0);
    checkOutput({tag, " lights1"}, 32'(lights1), 32'd0);
    checkOutput({tag, " busy2"}, 32'(busy2), 32'd0);
    checkOutput({tag, " finished2"}, 32'(fin2), 32'd0);
    checkOutput({tag, " lights2"}, 32'(lights2), 32'd0);
  endtask

  task automatic checkCycle(input int md, input int n, input int done1, input int done2);
    checkOutput("busy1", 32'(busy1), 32'(n >= 1 && n <= done1));
    checkOutput("finished1", 32'(fin1), 32'(n == done1));
    checkOutput("lights1", 32'(lights1), modelLights(N1, C1, S1, md, n, done1));
    checkOutput("busy2", 32'(busy2), 32'(n >= 1 && n <= done2));
    checkOutput("finished2", 32'(fin2), 32'(n == done2));
    checkOutput("lights2", 32'(lights2), modelLights(N2, C2, S2, md, n, done2));
  endtask

  // One run from accept through the first IDLE cycle after both instances end.
  task automatic applyStimulus(input int md, input int dur, input int abort_at, input bit rand_go);
    int ab, done1, done2, first, last;
    ab = ABORT_EN ? abort_at : -1;
    done1 = doneCycle(C1, dur, ab);
    done2 = doneCycle(C2, dur, ab);
    first = (done1 < done2) ? done1 : done2;
    last = (done1 > done2) ? done1 : done2;
    @(negedge clk);
    cycle = 0;
    checkIdle("pre-accept");
    go = 1'b1;
    mode = 2'(md);
    duration_ms = 16'(dur);
`ifdef LIGHT_PATTERN_ABORT_EN
    abort = (ab == 0);
`endif
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      cycle = n;
      go = (rand_go && n <= first) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode = 2'($urandom);
      duration_ms = 16'($urandom_range(0, 20));
`ifdef LIGHT_PATTERN_ABORT_EN
      abort = (n == ab);
`endif
      checkCycle(md, n, done1, done2);
    end
    go = 1'b0;
`ifdef LIGHT_PATTERN_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    int md, dur, ab;
    $display("[TB] start");
    repeat (2) begin
      @(negedge clk);
      checkIdle("in reset");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycle = i;
      checkIdle("idle");
    end

    applyStimulus(0, 3, -1, 1'b0);
    applyStimulus(1, 9, -1, 1'b0);
    applyStimulus(3, 2, -1, 1'b0);
    applyStimulus(2, 2, -1, 1'b0);
    applyStimulus(1, 0, -1, 1'b1);
    applyStimulus(2, 4, -1, 1'b1);
    applyStimulus(1, 3, 5, 1'b0);
    applyStimulus(3, 2, 9, 1'b0);
    applyStimulus(0, 2, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      md = int'($urandom_range(0, 3));
      dur = int'($urandom_range(0, 6));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, dur * C1 + 3)) : -1;
      applyStimulus(md, dur, ab, 1'b1);
    end

    @(negedge clk);
    cycle = 0;
    go = 1'b1;
    mode = 2'd1;
    duration_ms = 16'd5;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      cycle = n;
      go = 1'b0;
      checkCycle(1, n, doneCycle(C1, 5, -1), doneCycle(C2, 5, -1));
    end
    #2 rst_n = 1'b0;
    #1 checkIdle("async reset");
    @(negedge clk);
    checkIdle("held reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkIdle("after reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
